act_writeback: RTL and testbench
================================

// Module: act_writeback
// PURPOSE
//   Downstream of the accumulator stage. Captures each quantized NUM_LANES x int8 output vector,
//   applies the activation function and buffers it in a small FIFO. It then serializes the vector
//   into BUS_WIDTH beats and writes them to the output buffer over a valid/ready write port at
//   consecutive word addresses. The job is defined by a base address and a vector count.
// PARAMETERS
//   NUM_LANES   16  lanes per input vector (matches accumulator NUM_INPUTS)
//   DATA_WIDTH  8   bits per lane, signed
//   BUS_WIDTH   32  write-port data width; BEATS = NUM_LANES*DATA_WIDTH/BUS_WIDTH (must divide exactly)
//   FIFO_DEPTH  4   vectors buffered (power of 2, >=2)
//   ADDR_WIDTH  16  word address width
// PORTS
//   clk         in   1                      clock
//   rst         in   1                      synchronous active-high reset
//   start       in   1                      1-cycle job start; ignored while busy
//   base_addr   in   ADDR_WIDTH             first word address, sampled on start
//   num_vectors in   16                     vectors in job, sampled on start
//   act_mode    in   2                      00 pass, 01 ReLU, 10 clip [0,clip_max], 11 = pass
//   clip_max    in   DATA_WIDTH             clip upper bound, signed, expected 0..127
//   in_data     in   [NUM_LANES][DATA_WIDTH] vector from accumulator data_out
//   in_valid    in   1                      vector present (accumulator valid_out)
//   in_ready    out  1                      FIFO not full
//   wr_en       out  1                      write beat valid
//   wr_addr     out  ADDR_WIDTH             write word address
//   wr_data     out  BUS_WIDTH              write beat data
//   wr_ready    in   1                      sink accepts beat when wr_en&&wr_ready
//   busy        out  1                      job in progress
//   done        out  1                      1-cycle pulse at job end
//   overflow    out  1                      sticky: vector dropped at full FIFO; cleared by accepted start
// BEHAVIOUR
//   Reset: all outputs 0; in_ready=1; FIFO empty; state IDLE; beat/vector counters 0.
//   Push: in_valid && !full -> activated vector written at the edge. Push is allowed in any state.
//     in_valid && full -> vector dropped, overflow<=1. This holds even if a pop occurs in the same cycle.
//   Activation (per lane, at push):
//     ReLU: x<0 -> 0.
//     clip: x<0 -> 0; x>clip_max (signed compare) -> clip_max.
//   FSM states IDLE, RUN, DONE:
//     IDLE --start--> RUN. Latch base_addr and num_vectors; beat=0, vec=0, busy=1.
//       If num_vectors==0, go to DONE instead.
//     RUN: wr_en = FIFO non-empty (combinational from registered count). wr_data = head beat.
//       Beat b carries lanes b*L..b*L+L-1, with L=BUS_WIDTH/DATA_WIDTH and the lowest lane in the LSBs.
//       wr_addr = latched base_addr + words issued so far (wraps mod 2^ADDR_WIDTH).
//       While wr_en is high and wr_ready is low, wr_en, wr_addr and wr_data hold stable.
//       On accept: beat++. After the last beat of a vector, pop the FIFO, beat=0, vec++.
//       After the last beat of vector num_vectors-1 -> DONE.
//     DONE: done=1 for one cycle, busy=0, wr_en=0 -> IDLE.
//   Latency: a vector pushed at edge T drives wr_en in cycle T+1.
//     With wr_ready tied high, one vector takes BEATS cycles.
//   Surplus vectors stay in the FIFO for the next job. start while busy has no effect.
//   rst mid-job: FIFO is flushed and every counter and output returns to its reset value.
// TESTING
//   1. ReLU, base 0x0100, 1 vector lanes 0..15 = -8..7, wr_ready=1
//      -> 4 beats at 0x0100..0x0103; beat0 = 0x00000000, beat3 = 0x07060504; done 1 cycle after last.
//   2. clip, clip_max=6, lanes all 0x7F / 0x80 alternating -> every lane 0x06 or 0x00.
//   3. 3 vectors, wr_ready toggling 1-0-1 -> 12 beats, address and data held during stalls, no gaps or repeats.
//   4. 6 back-to-back in_valid, wr_ready=0, FIFO_DEPTH=4
//      -> in_ready low after 4; vectors 5 and 6 dropped; overflow=1 until next start.
//   5. start with num_vectors=0 -> done the cycle after start, no wr_en.
//      start while busy -> ignored.
//   6. rst asserted mid-beat of job 2 of 3 -> next cycle: wr_en=0, busy=0, in_ready=1, FIFO empty.

Source files
------------

// File: rtl/act_writeback_if.sv
// Vector-in / write-out bus of the activation write-back stage.
// The master view belongs to act_writeback. It consumes vectors and masters the write port.
// The slave view belongs to the surrounding logic: the accumulator and the output buffer.
interface act_writeback_if #(
    parameter int NUM_LANES  = 16,
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 16
);
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] in_data;
    logic                                 in_valid;
    logic                                 in_ready;
    logic                                 wr_en;
    logic [ADDR_WIDTH-1:0]                wr_addr;
    logic [BUS_WIDTH-1:0]                 wr_data;
    logic                                 wr_ready;

    modport master (
        input  in_data, in_valid, wr_ready,
        output in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output in_data, in_valid, wr_ready,
        input  in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/act_writeback.sv
// Activation write-back stage.
// It activates each incoming int8 vector and buffers it in a small FIFO.
// During a job it streams the buffered vectors out as BUS_WIDTH beats at consecutive word addresses.
module act_writeback #(
    parameter int NUM_LANES  = 16,
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [15:0]           num_vectors,
    input  logic [1:0]            act_mode,
    input  logic [DATA_WIDTH-1:0] clip_max,
    act_writeback_if.master       bus,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);
    localparam int VEC_W  = NUM_LANES * DATA_WIDTH;
    localparam int BEATS  = VEC_W / BUS_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Per-lane activation.
    // Clip treats negative inputs as ReLU does, then bounds the result from above with a signed compare.
    function automatic logic [DATA_WIDTH-1:0] activate(
        input logic [DATA_WIDTH-1:0] x,
        input logic [1:0]            mode,
        input logic [DATA_WIDTH-1:0] cmax
    );
        logic [DATA_WIDTH-1:0] y;
        y = x;
        case (mode)
            2'b01: begin
                if (x[DATA_WIDTH-1]) y = {DATA_WIDTH{1'b0}};
                else                 y = x;
            end
            2'b10: begin
                if (x[DATA_WIDTH-1])                y = {DATA_WIDTH{1'b0}};
                else if ($signed(x) > $signed(cmax)) y = cmax;
                else                                 y = x;
            end
            default: y = x;
        endcase
        return y;
    endfunction

    state_t                               state_r, state_next_s;
    logic [VEC_W-1:0]                     mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]                     wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]                     count_r;
    logic [BEAT_W-1:0]                    beat_r;
    logic [15:0]                          vec_r, num_r;
    logic [ADDR_WIDTH-1:0]                addr_r;
    logic                                 overflow_r;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] act_vec_s;
    logic [BEATS-1:0][BUS_WIDTH-1:0]      head_s;
    logic full_s, push_s, wr_en_s, accept_s, last_beat_s, last_vec_s, pop_s, start_ok_s;

    assign full_s      = (count_r == CNT_W'(FIFO_DEPTH));
    assign push_s      = bus.in_valid && !full_s;
    assign wr_en_s     = (state_r == ST_RUN) && (count_r != {CNT_W{1'b0}});
    assign accept_s    = wr_en_s && bus.wr_ready;
    assign last_beat_s = (beat_r == BEAT_W'(BEATS - 1));
    assign last_vec_s  = (vec_r == (num_r - 16'd1));
    assign pop_s       = accept_s && last_beat_s;
    assign start_ok_s  = start && (state_r == ST_IDLE);
    assign head_s      = mem_r[rd_ptr_r];

    assign bus.in_ready = !full_s;
    assign bus.wr_en    = wr_en_s;
    assign bus.wr_addr  = addr_r;
    assign bus.wr_data  = wr_en_s ? head_s[beat_r] : {BUS_WIDTH{1'b0}};
    assign busy         = (state_r == ST_RUN);
    assign done         = (state_r == ST_DONE);
    assign overflow     = overflow_r;

    // Activate every lane of the incoming vector before it is stored.
    always_comb begin
        act_vec_s = {VEC_W{1'b0}};
        for (int i = 0; i < NUM_LANES; i++) begin
            act_vec_s[i] = activate(bus.in_data[i], act_mode, clip_max);
        end
    end

    // Next-state logic for the job FSM. A zero-length job goes straight to DONE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (num_vectors == 16'd0) state_next_s = ST_DONE;
                    else                      state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (pop_s && last_vec_s) state_next_s = ST_DONE;
                else                     state_next_s = ST_RUN;
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_next_s;
    end

    // FIFO payload store. It is never reset because the count and pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= act_vec_s;
    end

    // FIFO pointers and occupancy. Push and pop are independent, and the pointers wrap at the power-of-2 depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Job bookkeeping: job parameters are latched on start, then the beat, vector and address counters advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_r <= {BEAT_W{1'b0}};
            vec_r  <= 16'd0;
            num_r  <= 16'd0;
            addr_r <= {ADDR_WIDTH{1'b0}};
        end else if (start_ok_s) begin
            beat_r <= {BEAT_W{1'b0}};
            vec_r  <= 16'd0;
            num_r  <= num_vectors;
            addr_r <= base_addr;
        end else if (accept_s) begin
            addr_r <= addr_r + ADDR_WIDTH'(1);
            if (last_beat_s) begin
                beat_r <= {BEAT_W{1'b0}};
                vec_r  <= vec_r + 16'd1;
            end else begin
                beat_r <= beat_r + BEAT_W'(1);
            end
        end else begin
            beat_r <= beat_r;
        end
    end

    // Sticky drop flag.
    // An accepted start clears it, but a drop in that same cycle still sets it.
    always_ff @(posedge clk) begin
        if (rst)                           overflow_r <= 1'b0;
        else if (bus.in_valid && full_s)   overflow_r <= 1'b1;
        else if (start_ok_s)               overflow_r <= 1'b0;
        else                               overflow_r <= overflow_r;
    end
endmodule

// File: tb/tb_act_writeback.sv
// Directed self-checking bench for act_writeback: table of single-vector jobs plus hand sequences.
module tb_act_writeback;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] base_addr, num_vectors;
    logic [1:0]  act_mode;
    logic [7:0]  clip_max;
    logic        busy, done, overflow;
    int          n_checks = 0;
    int          n_fail   = 0;

    act_writeback_if #(.NUM_LANES(16), .DATA_WIDTH(8), .BUS_WIDTH(32), .ADDR_WIDTH(16)) bus ();

    act_writeback #(.NUM_LANES(16), .DATA_WIDTH(8), .BUS_WIDTH(32), .FIFO_DEPTH(4), .ADDR_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_vectors(num_vectors),
        .act_mode(act_mode), .clip_max(clip_max), .bus(bus), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]   mode;
        logic [7:0]   cmax;
        logic [127:0] vec;
        logic [15:0]  base;
        logic [127:0] exp;
    } vec_case_t;

    localparam logic [127:0] VA = 128'h07060504_03020100_FFFEFDFC_FBFAF9F8; // lanes -8..7
    localparam logic [127:0] VB = 128'h807F807F_807F807F_807F807F_807F807F; // 0x7F / 0x80 alternating
    localparam logic [127:0] VC = 128'h0F0E0D0C_0B0A0908_07060504_03020100; // lanes 0..15
    localparam logic [127:0] VE = 128'h11223344_55667788_99AABBCC_DDEEFF00;

    vec_case_t   tbl [7];
    logic [15:0] got_addr [64];
    logic [31:0] got_data [64];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vec(input logic [127:0] v);
        bus.in_data  = v;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic start_job(input logic [15:0] base, input logic [15:0] n);
        base_addr   = base;
        num_vectors = n;
        start       = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drive wr_ready (always high, or 1-0-1 toggling) and record accepted beats.
    // Stall stability and optional no-gap behaviour are checked every cycle.
    task automatic collect(input int nb, input bit toggle, input bit no_gap, input int budget);
        int          n = 0;
        int          cyc = 0;
        logic        prev_stall = 1'b0;
        logic [15:0] prev_addr = 16'h0;
        logic [31:0] prev_data = 32'h0;
        while (n < nb && cyc < budget) begin
            bus.wr_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (prev_stall) begin
                check("stall_hold_en", bus.wr_en, 1'b1);
                check("stall_hold_addr", bus.wr_addr, prev_addr);
                check("stall_hold_data", bus.wr_data, prev_data);
            end
            if (no_gap) check("no_gap_wr_en", bus.wr_en, 1'b1);
            if (bus.wr_en && bus.wr_ready) begin
                got_addr[n] = bus.wr_addr;
                got_data[n] = bus.wr_data;
                n++;
            end
            prev_stall = bus.wr_en && !bus.wr_ready;
            prev_addr  = bus.wr_addr;
            prev_data  = bus.wr_data;
            tick();
            cyc++;
        end
        bus.wr_ready = 1'b1;
        check("beat_count", n, nb);
    endtask

    task automatic check_done_pulse();
        check("done_pulse", done, 1'b1);
        check("busy_in_done", busy, 1'b0);
        check("wr_en_in_done", bus.wr_en, 1'b0);
        tick();
        check("done_cleared", done, 1'b0);
    endtask

    initial begin
        logic [127:0] vv [3];
        logic [127:0] cur;
        logic [15:0]  ea;

        tbl[0] = '{2'b01, 8'd0, VA, 16'h0100, 128'h07060504_03020100_00000000_00000000};
        tbl[1] = '{2'b10, 8'd6, VB, 16'h0200, 128'h00060006_00060006_00060006_00060006};
        tbl[2] = '{2'b00, 8'd0, VA, 16'hFFFE, 128'h07060504_03020100_FFFEFDFC_FBFAF9F8};
        tbl[3] = '{2'b11, 8'd0, VB, 16'h0010, 128'h807F807F_807F807F_807F807F_807F807F};
        tbl[4] = '{2'b01, 8'd0, VB, 16'h0020, 128'h007F007F_007F007F_007F007F_007F007F};
        tbl[5] = '{2'b10, 8'd6, VA, 16'h0030, 128'h06060504_03020100_00000000_00000000};
        tbl[6] = '{2'b10, 8'd0, VA, 16'h0040, 128'h00000000_00000000_00000000_00000000};

        rst = 1'b1; start = 1'b0; base_addr = 16'h0; num_vectors = 16'h0;
        act_mode = 2'b00; clip_max = 8'd0;
        bus.in_data = 128'h0; bus.in_valid = 1'b0; bus.wr_ready = 1'b1;
        repeat (3) tick();
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_wr_en", bus.wr_en, 1'b0);
        check("rst_wr_addr", bus.wr_addr, 16'h0);
        check("rst_wr_data", bus.wr_data, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        rst = 1'b0;
        tick();

        // Single-vector jobs driven from the table
        for (int i = 0; i < 7; i++) begin
            act_mode = tbl[i].mode;
            clip_max = tbl[i].cmax;
            push_vec(tbl[i].vec);
            start_job(tbl[i].base, 16'd1);
            check("busy_after_start", busy, 1'b1);
            collect(4, 1'b0, 1'b1, 20);
            cur = tbl[i].exp;
            for (int b = 0; b < 4; b++) begin
                ea = tbl[i].base + 16'(b);
                check("tbl_addr", got_addr[b], ea);
                check("tbl_data", got_data[b], cur[b*32 +: 32]);
            end
            check_done_pulse();
        end

        // Latency: with the job already running, a vector pushed at edge T shows wr_en in cycle T+1
        act_mode = 2'b00;
        start_job(16'h0300, 16'd1);
        check("idle_run_no_data", bus.wr_en, 1'b0);
        push_vec(VC);
        check("latency_wr_en", bus.wr_en, 1'b1);
        check("latency_addr", bus.wr_addr, 16'h0300);
        check("latency_data", bus.wr_data, 32'h03020100);
        collect(4, 1'b0, 1'b1, 20);
        check_done_pulse();

        // Three vectors with wr_ready toggling 1-0-1
        vv[0] = VA; vv[1] = VB; vv[2] = VC;
        for (int k = 0; k < 3; k++) push_vec(vv[k]);
        start_job(16'h0500, 16'd3);
        collect(12, 1'b1, 1'b1, 60);
        for (int k = 0; k < 12; k++) begin
            cur = vv[k / 4];
            ea  = 16'h0500 + 16'(k);
            check("toggle_addr", got_addr[k], ea);
            check("toggle_data", got_data[k], cur[(k % 4)*32 +: 32]);
        end
        check_done_pulse();

        // Six back-to-back vectors into a depth-4 FIFO with no drain
        bus.wr_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.in_data  = {16{8'(k + 1)}};
            bus.in_valid = 1'b1;
            check("ovf_in_ready", bus.in_ready, (k < 4));
            tick();
        end
        bus.in_valid = 1'b0;
        check("ovf_set", overflow, 1'b1);
        repeat (3) tick();
        check("ovf_sticky", overflow, 1'b1);
        check("ovf_full_in_ready", bus.in_ready, 1'b0);
        start_job(16'h0600, 16'd4);
        check("ovf_cleared_by_start", overflow, 1'b0);
        collect(16, 1'b0, 1'b1, 40);
        for (int k = 0; k < 16; k++) begin
            check("ovf_kept_data", got_data[k], {4{8'(k / 4 + 1)}});
        end
        check_done_pulse();
        check("ovf_in_ready_back", bus.in_ready, 1'b1);

        // Zero-length job, with a leftover vector in the FIFO that must not be written
        push_vec(VC);
        start_job(16'h0700, 16'd0);
        check("zero_done", done, 1'b1);
        check("zero_busy", busy, 1'b0);
        check("zero_wr_en", bus.wr_en, 1'b0);
        tick();
        check("zero_done_clear", done, 1'b0);
        check("zero_idle_wr_en", bus.wr_en, 1'b0);

        // A start while busy is ignored; the leftover vector is written by this job
        bus.wr_ready = 1'b0;
        start_job(16'h0800, 16'd2);
        check("busy_job_addr", bus.wr_addr, 16'h0800);
        start_job(16'h0900, 16'd1);
        check("ignored_start_addr", bus.wr_addr, 16'h0800);
        check("ignored_start_busy", busy, 1'b1);
        push_vec(VE);
        vv[0] = VC; vv[1] = VE;
        collect(8, 1'b0, 1'b1, 40);
        for (int k = 0; k < 8; k++) begin
            cur = vv[k / 4];
            ea  = 16'h0800 + 16'(k);
            check("surplus_addr", got_addr[k], ea);
            check("surplus_data", got_data[k], cur[(k % 4)*32 +: 32]);
        end
        check_done_pulse();

        // Reset in the middle of the second vector of a three-vector job
        push_vec(VA); push_vec(VB); push_vec(VC);
        start_job(16'h0A00, 16'd3);
        collect(6, 1'b0, 1'b1, 20);
        rst = 1'b1;
        tick();
        check("midrst_wr_en", bus.wr_en, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_in_ready", bus.in_ready, 1'b1);
        check("midrst_done", done, 1'b0);
        check("midrst_wr_addr", bus.wr_addr, 16'h0);
        check("midrst_wr_data", bus.wr_data, 32'h0);
        rst = 1'b0;
        tick();
        start_job(16'h0B00, 16'd1);
        check("flushed_fifo_empty", bus.wr_en, 1'b0);
        push_vec(VE);
        collect(4, 1'b0, 1'b1, 20);
        check("flushed_first_data", got_data[0], 32'hDDEEFF00);
        check("flushed_first_addr", got_addr[0], 16'h0B00);
        check_done_pulse();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
